axis_tag_fifo: RTL and testbench
================================

AXIS_TAG_FIFO -- requirements
Module: axis_tag_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 64, tag word width in bits.
REQ-002 Parameter USER_WIDTH, default 32, tuser width in bits.
REQ-003 Parameter KEEP_WIDTH, default (DATA_WIDTH+7)/8, tkeep width in bits.
REQ-004 Parameter DEPTH, default 16, entry count; SHALL be a power of two and >= 2.
REQ-005 Parameter ALMOST_FULL_LEVEL, default DEPTH-4, fill level at which almost_full asserts.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 s_tvalid, s_tdata, s_tkeep, s_tuser, s_tlast  input  1/DATA_WIDTH/KEEP_WIDTH/USER_WIDTH/1  upstream AXI-Stream slave payload.
REQ-009 s_tready  output  1  slave ready.
REQ-010 m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast  output  1/DATA_WIDTH/KEEP_WIDTH/USER_WIDTH/1  downstream AXI-Stream master payload.
REQ-011 m_tready  input  1  downstream ready.
REQ-012 level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-013 almost_full  output  1  level >= ALMOST_FULL_LEVEL.
REQ-014 drop_count  output  32  dropped words; present only with AXIS_TAG_FIFO_OVERFLOW_CNT_EN.

Function
REQ-015 Storage: circular buffer of DEPTH entries, each {tdata, tkeep, tuser, tlast}; write/read pointers $clog2(DEPTH)+1 bits wide with wrap bit; full = address bits equal, wrap bits differ; empty = pointers equal.
REQ-016 Write occurs on an edge with s_tvalid && s_tready; read occurs on an edge with m_tvalid && m_tready.
REQ-017 Ordering: words leave in arrival order, payload and tlast bit-exact.
REQ-018 Latency: a word written into an empty FIFO at edge N drives m_tvalid=1 and its payload in the cycle after edge N; no combinational path from s_* to m_*.
REQ-019 m_tvalid = !empty; m_* payload = entry at read pointer; payload stable while m_tvalid && !m_tready.
REQ-020 s_tready = !full (backpressure mode); no combinational path from m_tready to s_tready.
REQ-021 Simultaneous read and write when neither full nor empty: both happen, level unchanged.
REQ-022 When full, a read frees one entry; s_tready rises the following cycle, never in the same cycle.
REQ-023 When empty, a write is never read out in the same cycle.
REQ-024 level updates on the edge of each read/write: +1 write only, -1 read only, unchanged for both or neither.
REQ-025 almost_full is registered, consistent with level in the same cycle.
REQ-026 Pointer wrap: DEPTH-1 -> 0 on the address bits with wrap-bit toggle; continuous streaming across wrap SHALL lose no words.

Reset
REQ-027 While rst=1 on an edge: pointers=0, level=0, m_tvalid=0, almost_full=0, drop_count=0 (if present); storage contents not cleared.
REQ-028 s_tready=0 during the reset cycle and 1 from the first cycle after rst deasserts.
REQ-029 Reset mid-transfer discards all stored words; no partial packet is emitted after reset.

Configuration
REQ-030 Macro AXIS_TAG_FIFO_OVERFLOW_CNT_EN defined: s_tready held 1 except during reset; a word presented with s_tvalid=1 while full is dropped, drop_count increments by 1, saturating at 0xFFFF_FFFF; stored words are unaffected.
REQ-031 Macro AXIS_TAG_FIFO_OVERFLOW_CNT_EN undefined: backpressure per REQ-020; drop_count port and counter absent.

Verification
REQ-032 Reset, then write 0x1..0x5 with m_tready=1 -> m_tdata 0x1..0x5 in order, first m_tvalid the cycle after first write.
REQ-033 DEPTH=16, m_tready=0, write 16 words -> level=16, s_tready=0, almost_full=1 from level 12; one read -> s_tready=1 next cycle.
REQ-034 Continuous write+read for 40 words with m_tready toggling pseudo-randomly -> 40 words in order, tkeep/tuser/tlast intact across pointer wraps.
REQ-035 Level 8, simultaneous s_tvalid and m_tready for 10 cycles -> level stays 8.
REQ-036 Level 10, assert rst for one cycle -> level=0, m_tvalid=0; next written word 0xAA is the first output.
REQ-037 With AXIS_TAG_FIFO_OVERFLOW_CNT_EN, fill to 16, present 3 more words -> drop_count=3, output holds the original 16 words only.

Source files
------------

// File: rtl/axis_tag_fifo.sv
// AXI-Stream tag FIFO: circular buffer of {tdata, tkeep, tuser, tlast} with level and almost_full.
// Build option AXIS_TAG_FIFO_OVERFLOW_CNT_EN: never backpressure, drop words offered while full and count them.
module axis_tag_fifo #(
    parameter int DATA_WIDTH        = 64,
    parameter int USER_WIDTH        = 32,
    parameter int KEEP_WIDTH        = (DATA_WIDTH + 7) / 8,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      s_tvalid_i,
    input  logic [DATA_WIDTH-1:0]     s_tdata_i,
    input  logic [KEEP_WIDTH-1:0]     s_tkeep_i,
    input  logic [USER_WIDTH-1:0]     s_tuser_i,
    input  logic                      s_tlast_i,
    output logic                      s_tready_o,

    output logic                      m_tvalid_o,
    output logic [DATA_WIDTH-1:0]     m_tdata_o,
    output logic [KEEP_WIDTH-1:0]     m_tkeep_o,
    output logic [USER_WIDTH-1:0]     m_tuser_o,
    output logic                      m_tlast_o,
    input  logic                      m_tready_i,

    output logic [$clog2(DEPTH):0]    level_o,
`ifdef AXIS_TAG_FIFO_OVERFLOW_CNT_EN
    output logic [31:0]               drop_count_o,
`endif
    output logic                      almost_full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
    // One extra bit so thresholds above DEPTH simply never assert.
    localparam logic [PW:0] AF_LEVEL = (PW + 1)'(ALMOST_FULL_LEVEL);

    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          almost_full_q;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Ready depends only on registered state and reset, never on m_tready_i.
`ifdef AXIS_TAG_FIFO_OVERFLOW_CNT_EN
    assign s_tready_o = !rst_i;
`else
    assign s_tready_o = !rst_i && !full;
`endif

    assign wr_en = s_tvalid_i && s_tready_o && !full;
    assign rd_en = !empty && m_tready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + PW'(1);
            2'b01:   level_d = level_q - PW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            almost_full_q <= ({1'b0, level_d} >= AF_LEVEL);
        end
    end

    // Storage is intentionally not reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_tdata_i, s_tkeep_i, s_tuser_i, s_tlast_i};
        end
    end

    assign m_tvalid_o = !empty;
    assign {m_tdata_o, m_tkeep_o, m_tuser_o, m_tlast_o} = mem_q[rd_ptr_q[AW-1:0]];

    assign level_o       = level_q;
    assign almost_full_o = almost_full_q;

`ifdef AXIS_TAG_FIFO_OVERFLOW_CNT_EN
    logic [31:0] drop_count_q;
    logic        drop;

    assign drop = s_tvalid_i && s_tready_o && full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_count_q <= '0;
        end else if (drop && (drop_count_q != 32'hFFFF_FFFF)) begin
            drop_count_q <= drop_count_q + 32'd1;
        end
    end

    assign drop_count_o = drop_count_q;
`endif

endmodule

// File: tb/tb_axis_tag_fifo.sv
// Directed bench for axis_tag_fifo (DEPTH=16); the AXIS_TAG_FIFO_OVERFLOW_CNT_EN build adds the drop section.
module tb_axis_tag_fifo;

`ifdef AXIS_TAG_FIFO_OVERFLOW_CNT_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic [31:0] s_tuser;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [31:0] m_tuser;
    logic        m_tlast;
    logic        m_tready;
    logic [4:0]  level;
    logic        almost_full;
`ifdef AXIS_TAG_FIFO_OVERFLOW_CNT_EN
    logic [31:0] drop_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    axis_tag_fifo dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_tvalid_i    (s_tvalid),
        .s_tdata_i     (s_tdata),
        .s_tkeep_i     (s_tkeep),
        .s_tuser_i     (s_tuser),
        .s_tlast_i     (s_tlast),
        .s_tready_o    (s_tready),
        .m_tvalid_o    (m_tvalid),
        .m_tdata_o     (m_tdata),
        .m_tkeep_o     (m_tkeep),
        .m_tuser_o     (m_tuser),
        .m_tlast_o     (m_tlast),
        .m_tready_i    (m_tready),
        .level_o       (level),
`ifdef AXIS_TAG_FIFO_OVERFLOW_CNT_EN
        .drop_count_o  (drop_count),
`endif
        .almost_full_o (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sdata(int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k);
    endfunction

    function automatic logic [7:0] skeep(int k);
        return 8'(k * 37) ^ 8'h5A;
    endfunction

    function automatic logic [31:0] suser(int k);
        return 32'hA000_0000 + 32'(k * 3);
    endfunction

    function automatic logic slast(int k);
        return (k % 4) == 3;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pat;
        int snd, rcv, cyc;
        logic s_fire, r_fire;

        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = 8'hFF;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;

        // reset state
        step();
        step();
        chk("rst_tready", s_tready, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_level", level, 0);
        chk("rst_afull", almost_full, 0);
`ifdef AXIS_TAG_FIFO_OVERFLOW_CNT_EN
        chk("rst_drops", drop_count, 0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_tready", s_tready, 1);

        // five words in order with reader always ready
        m_tready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'(i);
            #1;
            if (i == 1) chk("no_same_cycle", m_tvalid, 0);
            step();
            chk("seq_valid", m_tvalid, 1);
            chk("seq_data", m_tdata, 64'(i));
            chk("seq_level", level, 1);
        end
        s_tvalid = 1'b0;
        step();
        chk("seq_drained", m_tvalid, 0);
        chk("seq_level0", level, 0);

        // fill to DEPTH, almost_full threshold, ready returns one cycle after a read
        m_tready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'h100 + 64'(k);
            step();
            chk("fill_level", level, 64'(k + 1));
            chk("fill_afull", almost_full, (k + 1) >= 12);
        end
        s_tvalid = 1'b0;
        chk("full_tready", s_tready, OVF);
        chk("full_head", m_tdata, 64'h100);
        m_tready = 1'b1;
        #1;
        chk("full_rd_tready", s_tready, OVF);
        step();
        m_tready = 1'b0;
        chk("after_rd_tready", s_tready, 1);
        chk("after_rd_level", level, 15);
        chk("after_rd_afull", almost_full, 1);
        m_tready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("drain_data", m_tdata, 64'h100 + 64'(i));
            step();
        end
        m_tready = 1'b0;
        chk("drain_empty", m_tvalid, 0);
        chk("drain_level", level, 0);
        chk("drain_afull", almost_full, 0);

        // 40-word stream with irregular reader across pointer wraps
        pat = 32'hB7D3_6E5B;
        snd = 0;
        rcv = 0;
        cyc = 0;
        while (rcv < 40 && cyc < 400) begin
            s_tvalid = (snd < 40) && ((snd - rcv) < 16);
            s_tdata  = sdata(snd);
            s_tkeep  = skeep(snd);
            s_tuser  = suser(snd);
            s_tlast  = slast(snd);
            m_tready = pat[cyc % 32];
            #1;
            s_fire = s_tvalid && s_tready;
            r_fire = m_tvalid && m_tready;
            if (r_fire) begin
                chk("strm_data", m_tdata, sdata(rcv));
                chk("strm_keep", m_tkeep, skeep(rcv));
                chk("strm_user", m_tuser, suser(rcv));
                chk("strm_last", m_tlast, slast(rcv));
            end
            step();
            if (s_fire) snd++;
            if (r_fire) rcv++;
            cyc++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        s_tkeep  = 8'hFF;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        chk("strm_count", 64'(rcv), 40);
        chk("strm_level", level, 0);

        // level 8 held under simultaneous read and write
        for (int k = 0; k < 8; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'h200 + 64'(k);
            step();
        end
        chk("lvl8", level, 8);
        m_tready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            s_tdata = 64'h208 + 64'(j);
            chk("rw_data", m_tdata, 64'h200 + 64'(j));
            step();
            chk("rw_level", level, 8);
        end
        m_tready = 1'b0;

        // reset at level 10 discards everything
        s_tdata = 64'h212;
        step();
        s_tdata = 64'h213;
        step();
        s_tvalid = 1'b0;
        chk("lvl10", level, 10);
        rst = 1'b1;
        step();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_tvalid", m_tvalid, 0);
        chk("mid_rst_tready", s_tready, 0);
        chk("mid_rst_afull", almost_full, 0);
        rst      = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 64'hAA;
        s_tlast  = 1'b1;
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("aa_valid", m_tvalid, 1);
        chk("aa_data", m_tdata, 64'hAA);
        chk("aa_last", m_tlast, 1);
        chk("aa_level", level, 1);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        chk("aa_empty", m_tvalid, 0);

`ifdef AXIS_TAG_FIFO_OVERFLOW_CNT_EN
        // overflow: three extra words are dropped and counted
        for (int k = 0; k < 16; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'h300 + 64'(k);
            step();
        end
        for (int j = 0; j < 3; j++) begin
            s_tdata = 64'h3F0 + 64'(j);
            chk("ovf_tready", s_tready, 1);
            step();
        end
        s_tvalid = 1'b0;
        chk("ovf_drops", drop_count, 3);
        chk("ovf_level", level, 16);
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_data", m_tdata, 64'h300 + 64'(i));
            step();
        end
        m_tready = 1'b0;
        chk("ovf_empty", m_tvalid, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
